// File: rtl/gpio_rmw_pkg.sv
// gpio_rmw_pkg: op encodings, sequencer state encoding and default stall limit
package gpio_rmw_pkg;
  localparam logic [2:0] OP_READ = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_SET = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam int DEF_TIMEOUT = 15;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;
endpackage

// File: rtl/gpio_rmw_wdog.sv
// gpio_rmw_wdog: bus phase watchdog, expired once en has held LIMIT cycles since load
module gpio_rmw_wdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
  assign expired = en & (cnt_q == 8'(LIMIT - 1));
endmodule

// File: rtl/gpio_rmw_master.sv
// gpio_rmw_master: command-to-Wishbone read-modify-write sequencer (stall timeout under GPIO_RMW_TIMEOUT_EN)
module gpio_rmw_master
  import gpio_rmw_pkg::*;
#(
  parameter int WB_ADR_WIDTH = 4,
  parameter int WB_DAT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [WB_ADR_WIDTH-1:0] cmd_adr,
  input  logic [WB_DAT_WIDTH-1:0] cmd_mask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WB_DAT_WIDTH-1:0] rsp_data,
  output logic                    rsp_err,
  output logic [WB_ADR_WIDTH-1:0] wbm_adr_o,
  output logic [WB_DAT_WIDTH-1:0] wbm_dat_o,
  output logic                    wbm_we_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  input  logic                    wbm_ack_i,
  input  logic [WB_DAT_WIDTH-1:0] wbm_dat_i
);
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0] mask_q, mask_d, dat_q, dat_d, alu;
  logic err_q, err_d, tmo, illegal;
`ifdef GPIO_RMW_TIMEOUT_EN
  gpio_rmw_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk(wb_clk),
    .rst(wb_rst),
    .load(state_d != state_q),
    .en(wbm_cyc_o),
    .expired(tmo)
  );
`else
  localparam logic [7:0] UNUSED_TO = 8'(TIMEOUT_CYCLES);
  logic [7:0] unused_cfg;
  assign unused_cfg = UNUSED_TO;
  assign tmo = 1'b0;
`endif
  assign cmd_ready = (state_q == S_IDLE) & ~wb_rst;
  assign wbm_cyc_o = (state_q == S_RD) | (state_q == S_WR);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o = state_q == S_WR;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = state_q == S_RSP;
  assign rsp_data = dat_q;
  assign rsp_err = err_q;
  assign illegal = cmd_op > OP_TOGGLE;
  assign alu = op_q == OP_SET ? wbm_dat_i | mask_q :
               op_q == OP_CLEAR ? wbm_dat_i & ~mask_q :
               op_q == OP_TOGGLE ? wbm_dat_i ^ mask_q : wbm_dat_i;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    adr_d = adr_q;
    mask_d = mask_q;
    dat_d = dat_q;
    err_d = err_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid & cmd_ready) begin
        op_d = cmd_op;
        adr_d = cmd_adr;
        mask_d = cmd_mask;
        dat_d = illegal ? '0 : cmd_mask;
        err_d = illegal;
        state_d = illegal ? S_RSP : cmd_op == OP_WRITE ? S_WR : S_RD;
      end
      S_RD: if (wbm_ack_i) begin
        dat_d = alu;
        state_d = op_q == OP_READ ? S_RSP : S_WR;
      end else if (tmo) begin
        dat_d = '0;
        err_d = 1'b1;
        state_d = S_RSP;
      end
      S_WR: if (wbm_ack_i) begin
        state_d = S_RSP;
      end else if (tmo) begin
        dat_d = '0;
        err_d = 1'b1;
        state_d = S_RSP;
      end
      S_RSP: state_d = rsp_ready ? S_IDLE : S_RSP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= S_IDLE;
      op_q <= '0;
      adr_q <= '0;
      mask_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      adr_q <= adr_d;
      mask_q <= mask_d;
      dat_q <= dat_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/gpio_rmw_master.md
# gpio_rmw_master

Wishbone master sequencer driving the 8-bit GPIO Wishbone slave from a simple valid/ready command port. Turns single commands (read, write, bit set/clear/toggle) into one read and/or one write bus cycle. Holds `wbm_cyc_o` across the read-modify-write so the update is atomic. Sits between the control logic (CPU-less sequencers, test controllers) and the GPIO register bank.

## Interface
- `WB_ADR_WIDTH`, default 4: address width; matches the GPIO slave.
- `WB_DAT_WIDTH`, default 8: data width. Only 8 is supported.
- `TIMEOUT_CYCLES`, default 15: stalled-ack limit. Used only with `GPIO_RMW_TIMEOUT_EN`. Range 1..255.
- `wb_clk`  in  1: the single clock.
- `wb_rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  3: operation. 000 READ, 001 WRITE, 010 SET, 011 CLEAR, 100 TOGGLE; 101–111 illegal.
- `cmd_adr`  in  WB_ADR_WIDTH: target register address.
- `cmd_mask`  in  8: write data for WRITE; bit mask for SET/CLEAR/TOGGLE; ignored for READ.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_data`  out  8: READ returns the read value. WRITE/SET/CLEAR/TOGGLE return the value written. Error returns 0.
- `rsp_err`  out  1: illegal op or timeout.
- `wbm_adr_o`  out  WB_ADR_WIDTH: bus address.
- `wbm_dat_o`  out  8: bus write data.
- `wbm_we_o`  out  1: bus write enable.
- `wbm_cyc_o`  out  1: bus cycle.
- `wbm_stb_o`  out  1: bus strobe.
- `wbm_ack_i`  in  1: bus acknowledge.
- `wbm_dat_i`  in  8: bus read data.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - RD: cyc=1, stb=1, we=0.
  - WR: cyc=1, stb=1, we=1.
  - RSP: `rsp_valid`=1.
- Transitions:
  - IDLE on accept: READ/SET/CLEAR/TOGGLE → RD; WRITE → WR with `wbm_dat_o`=`cmd_mask`; illegal op → RSP with err=1, data=0, no bus cycle.
  - Command fields (op, adr, mask) are latched on accept.
- RD, ack sampled: latch `wbm_dat_i` as `rd`.
  - READ → RSP with data=`rd`.
  - SET → WR with `rd|mask`.
  - CLEAR → WR with `rd&~mask`.
  - TOGGLE → WR with `rd^mask`.
- WR, ack sampled → RSP with data=written value, err=0.
- RSP: `rsp_valid` and `rsp_data`/`rsp_err` are held stable until `rsp_ready`; then IDLE. `cmd_ready` is 0 throughout RSP.
- `wbm_cyc_o` stays high continuously from the RD entry through WR; it drops only on leaving WR (or RD for READ).
- `wbm_stb_o` drops for zero cycles between RD and WR; `wbm_we_o` changes on the same edge.
- `wbm_ack_i` is ignored outside RD/WR.
- `wbm_adr_o` equals the latched address whenever cyc=1.

## Timing
- `wb_rst` high at an edge forces IDLE and clears every output to 0, including an in-flight bus cycle (cyc/stb drop at that edge) and pending responses. `cmd_ready` is gated to 0 while `wb_rst` is high.
- `cmd_ready` is combinational from state (IDLE & !`wb_rst`).
- Per phase: stb asserts in the cycle after entry; the phase ends on the edge where ack=1 is sampled.
- Against the GPIO slave (ack one cycle after stb):
  - READ: accept at edge 0, stb cycles 1–2, `rsp_valid` from cycle 3.
  - SET/CLEAR/TOGGLE: RD in cycles 1–2, WR in cycles 3–4, `rsp_valid` from cycle 5.
  - WRITE: `rsp_valid` from cycle 3.
  - Illegal op: `rsp_valid` from cycle 1.
- Back-to-back: a new command is accepted no earlier than the cycle after the `rsp` handshake.

## Configuration
- `GPIO_RMW_TIMEOUT_EN` defined:
  - A counter runs while in RD or WR and clears on phase entry.
  - If it reaches `TIMEOUT_CYCLES` with no ack, cyc/stb drop on that edge and the block enters RSP with err=1, data=0.
  - No write follows a timed-out read.
  - An ack arriving on the same edge as expiry wins; the phase completes normally.
- Undefined: no counter. The block waits indefinitely for ack, and `rsp_err` reports illegal ops only.

## Structure
- Shared package `gpio_rmw_pkg` holds:
  - op encodings (OP_READ, OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE);
  - the state encoding;
  - the default timeout constant.
- One sub-module, `gpio_rmw_wdog` (load/enable/expired counter), instantiated only under `GPIO_RMW_TIMEOUT_EN`.
- The modify ALU stays inline.

## Test plan
- Bench: block connected to the 8-bit GPIO slave model (adr 0 data, adr 1 dir).
- WRITE adr 1, mask 0xFF → WR phase only; `rsp_valid` at cycle 3; `rsp_data`=0xFF; dir register reads 0xFF.
- Dir=0xFF, data=0x0F; SET adr 0, mask 0xA0 → one read then one write with cyc held high; `rsp_data`=0xAF; pins 0xAF.
- Following that: CLEAR adr 0, mask 0x0F → 0xA0; TOGGLE adr 0, mask 0xFF → 0x5F; READ adr 0 → `rsp_data`=0x5F, `wbm_we_o` never high.
- `cmd_op`=0b110 → `rsp_valid` at cycle 1, `rsp_err`=1, `rsp_data`=0, `wbm_cyc_o` stays 0.
- Hold `rsp_ready` low 10 cycles → `rsp` stable and `cmd_ready`=0 throughout. Then assert `wb_rst` mid-WR of a SET → cyc/stb and `rsp_valid` are 0 the next cycle, and the slave sees no further write.
- With `GPIO_RMW_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, slave ack tied low → stb drops after 4 cycles; `rsp_err`=1, data=0; the next command proceeds normally.
